// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, requester port ids, default bus widths and
// a small constant helper used to size the phase counter.
package mem_bus_pkg;

    // Default bus geometry of the memory module.
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    // Requester port ids; also the value stored in the round-robin pointer.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Bus sequencing phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Larger of two elaboration-time integers.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for mem_bus_arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are level-held until the matching done pulse.
//
// slave  : the arbiter side (consumes requests and bus_rdata, drives the bus).
// master : the requester / top-level side (drives requests and bus_rdata).
//   req0/we0/addr0/wdata0, req1/we1/addr1/wdata1 : requester inputs
//   done0/done1/rdata/busy                       : completion and status
//   bus_addr/bus_wdata/bus_oe/bus_rd/bus_wr      : memory bus controls
//   bus_rdata                                    : bus value sampled on reads
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W
);
    // Port 0: front-panel manual access.
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;

    // Port 1: scan / fill engine.
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;

    // Completion and status.
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // Memory bus towards the top-level tristate buffer.
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_oe;
    logic              bus_rd;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  bus_rdata,
        output done0, done1, rdata, busy,
        output bus_addr, bus_wdata, bus_oe, bus_rd, bus_wr
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output bus_rdata,
        input  done0, done1, rdata, busy,
        input  bus_addr, bus_wdata, bus_oe, bus_rd, bus_wr
    );

endinterface

// File: rtl/mem_bus_rr_arb.sv
// Two-way round-robin picker for the memory bus requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; enable gates the grant, the pointer lives in the parent.
//
// Ports:
//   req[1:0] : request vector, bit n = port n
//   last     : port granted most recently (tie goes to the other port)
//   enable   : arbitration allowed this cycle
//   grant    : winning port index
//   valid    : grant is meaningful and should be taken
module mem_bus_rr_arb
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = enable && (req != 2'b00);
        case (req)
            2'b11:   grant = (last == PORT0) ? PORT1 : PORT0;
            2'b10:   grant = PORT1;
            default: grant = PORT0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between two requesters and sequences setup/strobe/hold.
// Latency: done pulses 1+SETUP_CYCLES+STROBE_CYCLES cycles after the req is sampled in IDLE.
// Backpressure: req is level-held until done; one IDLE cycle separates transactions.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   io       : mem_bus_arbiter_if.slave (requests, done/rdata/busy, memory bus)
// Build option: MEM_BUS_FIXED_PRIO_EN gives port 0 priority on every tie and
// drops the round-robin pointer (port 1 can starve).
//
// All bus controls and done pulses come straight from flops: the next-cycle
// values are decoded from the next state and registered, so the strobes seen
// by the memory are glitch-free. As a result bus_oe and bus_rd can never
// overlap and bus_wr only rises inside a bus_oe window.
module mem_bus_arbiter #(
    parameter int ADDR_W        = mem_bus_pkg::ADDR_W,
    parameter int DATA_W        = mem_bus_pkg::DATA_W,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  io
);
    import mem_bus_pkg::*;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_STROBE = STROBE;
    localparam logic [1:0] ST_HOLD   = HOLD;

    // The counter holds "cycles left minus one" for the current phase, so it
    // only needs to represent max(SETUP,STROBE); the +1 keeps it safe at 255.
    localparam int CNT_MAX = max2(SETUP_CYCLES, STROBE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);

    // FSM and latched transaction.
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              port_q,   port_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    // Registered outputs.
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_oe_q,    bus_oe_d;
    logic              bus_rd_q,    bus_rd_d;
    logic              bus_wr_q,    bus_wr_d;
    logic              done0_q,     done0_d;
    logic              done1_q,     done1_d;
    logic              busy_q,      busy_d;

    // Arbitration.
    logic arb_grant;
    logic arb_vld;
    logic arb_last;

`ifdef MEM_BUS_FIXED_PRIO_EN
    // Pretending port 1 always went last makes every tie resolve to port 0.
    assign arb_last = PORT1;
`else
    logic last_q;

    // Reset to PORT1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT1;
        end else if (arb_vld) begin
            last_q <= arb_grant;
        end
    end

    assign arb_last = last_q;
`endif

    mem_bus_rr_arb u_arb (
        .req    ({io.req1, io.req0}),
        .last   (arb_last),
        .enable (state_q == ST_IDLE),
        .grant  (arb_grant),
        .valid  (arb_vld)
    );

    // Next state, counter and transaction latches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        port_d  = port_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    port_d  = arb_grant;
                    if (arb_grant == PORT1) begin
                        we_d    = io.we1;
                        addr_d  = io.addr1;
                        wdata_d = io.wdata1;
                    end else begin
                        we_d    = io.we0;
                        addr_d  = io.addr0;
                        wdata_d = io.wdata0;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    // Last strobe cycle: the memory has had the full strobe
                    // width to drive the bus.
                    if (!we_q) begin
                        rdata_d = io.bus_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode for the cycle being entered.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        // Writes keep the data driven through HOLD; reads leave the bus
        // released through HOLD so the memory can turn around.
        bus_oe_d    = busy_d && we_d;
        bus_rd_d    = !we_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE));
        bus_wr_d    = we_d && (state_d == ST_STROBE);
        bus_addr_d  = busy_d ? addr_d : '0;
        bus_wdata_d = bus_oe_d ? wdata_d : '0;
        done0_d     = (state_d == ST_HOLD) && (port_d == PORT0);
        done1_d     = (state_d == ST_HOLD) && (port_d == PORT1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            port_q      <= PORT0;
            rdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_oe_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            port_q      <= port_d;
            rdata_q     <= rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_oe_q    <= bus_oe_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            busy_q      <= busy_d;
        end
    end

    assign io.bus_addr  = bus_addr_q;
    assign io.bus_wdata = bus_wdata_q;
    assign io.bus_oe    = bus_oe_q;
    assign io.bus_rd    = bus_rd_q;
    assign io.bus_wr    = bus_wr_q;
    assign io.done0     = done0_q;
    assign io.done1     = done1_q;
    assign io.busy      = busy_q;
    assign io.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cycle checks plus a
// random phase with per-port scoreboards and a memory reference model.
// Build option: define MEM_BUS_FIXED_PRIO_EN to match a fixed-priority DUT.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if io ();

    mem_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    // Memory behind the tristate buffer, and the reference it must match.
    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];

    always @(posedge clk) begin
        if (io.bus_wr) mem[io.bus_addr] <= io.bus_wdata;
    end

    assign io.bus_rdata = io.bus_rd ? mem[io.bus_addr] : 8'h00;

    // Outstanding transactions per requester, pushed when driven.
    txn_t q0[$];
    txn_t q1[$];
    bit   pend0 = 1'b0;
    bit   pend1 = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit we, input logic [3:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        if (!port) begin
            io.req0 = 1'b1; io.we0 = we; io.addr0 = a; io.wdata0 = d;
            q0.push_back(t); pend0 = 1'b1;
        end else begin
            io.req1 = 1'b1; io.we1 = we; io.addr1 = a; io.wdata1 = d;
            q1.push_back(t); pend1 = 1'b1;
        end
    endtask

    // Pop the port's oldest transaction on its done pulse and check it
    // against the reference memory.
    task automatic complete(input bit port);
        txn_t t;
        if (!port) begin
            chk("done0_has_txn", 32'(q0.size() != 0), 32'd1);
            if (q0.size() == 0) return;
            t = q0.pop_front();
            pend0 = 1'b0;
        end else begin
            chk("done1_has_txn", 32'(q1.size() != 0), 32'd1);
            if (q1.size() == 0) return;
            t = q1.pop_front();
            pend1 = 1'b0;
        end
        if (t.we) ref_mem[t.addr] = t.wdata;
        else chk(port ? "rdata_p1" : "rdata_p0", 32'(io.rdata), 32'(ref_mem[t.addr]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_oe_rd", 32'(io.bus_oe && io.bus_rd), 32'd0);
            chk("inv_wr_oe", 32'(io.bus_wr && !io.bus_oe), 32'd0);
            chk("inv_one_done", 32'(io.done0 && io.done1), 32'd0);
            if (io.done0) complete(1'b0);
            if (io.done1) complete(1'b1);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done0"}, 32'(io.done0), 32'd0);
        chk({tag, "_done1"}, 32'(io.done1), 32'd0);
        chk({tag, "_busy"}, 32'(io.busy), 32'd0);
        chk({tag, "_oe"}, 32'(io.bus_oe), 32'd0);
        chk({tag, "_rd"}, 32'(io.bus_rd), 32'd0);
        chk({tag, "_wr"}, 32'(io.bus_wr), 32'd0);
        chk({tag, "_addr"}, 32'(io.bus_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(io.bus_wdata), 32'd0);
        chk({tag, "_rdata"}, 32'(io.rdata), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, limit 1ms", $time);
        $fatal(1);
    end

    initial begin
        int   n0_tgt, n1_tgt, last_c, d0, d1;
        txn_t t;
        bit   e0, e1;

        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst = 1'b1;
        io.req0 = 1'b0; io.we0 = 1'b0; io.addr0 = '0; io.wdata0 = '0;
        io.req1 = 1'b0; io.we1 = 1'b0; io.addr1 = '0; io.wdata1 = '0;
        repeat (3) step();
        @(negedge clk);
        chk_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // Single write on port 0.
        drive(1'b0, 1'b1, 4'h3, 8'hA5);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk("wr_oe", 32'(io.bus_oe), 32'(c <= 6));
                chk("wr_wr", 32'(io.bus_wr), 32'(c >= 2 && c <= 5));
                chk("wr_rd", 32'(io.bus_rd), 32'd0);
                chk("wr_addr", 32'(io.bus_addr), (c <= 6) ? 32'h3 : 32'h0);
                chk("wr_wdata", 32'(io.bus_wdata), (c <= 6) ? 32'hA5 : 32'h0);
                chk("wr_busy", 32'(io.busy), 32'(c <= 6));
                chk("wr_done0", 32'(io.done0), 32'(c == 6));
            end
            if (c == 6) io.req0 = 1'b0;
        end

        // Single read on port 1 of the location just written.
        step();
        drive(1'b1, 1'b0, 4'h3, 8'h00);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk("rd_rd", 32'(io.bus_rd), 32'(c <= 5));
                chk("rd_oe", 32'(io.bus_oe), 32'd0);
                chk("rd_wr", 32'(io.bus_wr), 32'd0);
                chk("rd_addr", 32'(io.bus_addr), (c <= 6) ? 32'h3 : 32'h0);
                chk("rd_done1", 32'(io.done1), 32'(c == 6));
                chk("rd_done0", 32'(io.done0), 32'd0);
                if (c == 6) chk("rd_rdata", 32'(io.rdata), 32'hA5);
            end
            if (c == 6) io.req1 = 1'b0;
        end

        // Contention: both ports write and hold their requests.
`ifdef MEM_BUS_FIXED_PRIO_EN
        n0_tgt = 4; n1_tgt = 1; last_c = 35;
`else
        n0_tgt = 2; n1_tgt = 2; last_c = 28;
`endif
        step();
        drive(1'b0, 1'b1, 4'h7, 8'h11);
        drive(1'b1, 1'b1, 4'h8, 8'h22);
        t = q0[0];
        for (int k = 1; k < n0_tgt; k++) q0.push_back(t);
        t = q1[0];
        for (int k = 1; k < n1_tgt; k++) q1.push_back(t);
        d0 = 0; d1 = 0;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (c >= 1) begin
`ifdef MEM_BUS_FIXED_PRIO_EN
                e0 = (c == 6) || (c == 13) || (c == 20) || (c == 27);
                e1 = (c == 34);
`else
                e0 = (c == 6) || (c == 20);
                e1 = (c == 13) || (c == 27);
`endif
                chk("ct_done0", 32'(io.done0), 32'(e0));
                chk("ct_done1", 32'(io.done1), 32'(e1));
            end
            if (io.done0) begin d0++; if (d0 == n0_tgt) io.req0 = 1'b0; end
            if (io.done1) begin d1++; if (d1 == n1_tgt) io.req1 = 1'b0; end
        end

        // Reset in the middle of a write strobe.
        step();
        drive(1'b0, 1'b1, 4'h5, 8'h3C);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("rst_pre_wr", 32'(io.bus_wr), 32'd1);
                rst = 1'b1;
                io.req0 = 1'b0;
                t = q0.pop_front();
                pend0 = 1'b0;
            end else if (c == 4) begin
                chk_all_zero("rst_mid");
                rst = 1'b0;
            end else if (c > 4) begin
                chk("rst_no_done", 32'(io.done0), 32'd0);
                chk("rst_idle", 32'(io.busy), 32'd0);
            end
        end
        step();
        drive(1'b0, 1'b1, 4'h5, 8'h3C);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk("post_rst_done0", 32'(io.done0), 32'(c == 6));
                chk("post_rst_busy", 32'(io.busy), 32'(c <= 6));
            end
            if (c == 6) io.req0 = 1'b0;
        end

        // Random traffic from both requesters.
        for (int i = 0; i < 1000; i++) begin
            step();
            if (!pend0) begin
                if ($urandom_range(0, 2) == 0)
                    drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                else
                    io.req0 = 1'b0;
            end
            if (!pend1) begin
                if ($urandom_range(0, 2) == 0)
                    drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                else
                    io.req1 = 1'b0;
            end
        end
        for (int i = 0; i < 200 && (pend0 || pend1); i++) begin
            step();
            if (!pend0) io.req0 = 1'b0;
            if (!pend1) io.req1 = 1'b0;
        end
        chk("drain_pending", 32'(pend0 || pend1), 32'd0);
        io.req0 = 1'b0;
        io.req1 = 1'b0;
        repeat (10) step();
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("final_idle", 32'(io.busy), 32'd0);
        for (int a = 0; a < 16; a++) begin
            chk($sformatf("mem_%0d", a), 32'(mem[a]), 32'(ref_mem[a]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the 4-bit-address / 8-bit-data memory bus (address, databus, rd, wr) between two requesters: port 0 (front-panel manual access) and port 1 (automatic scan or fill engine).
- Generates correctly timed setup / strobe / hold phases for rd and wr.
- Guarantees the top level and the memory never drive the data bus at the same time.
- Sits between the requesters and the top-level tristate buffer that feeds the memory module.

Parameters:
- ADDR_W, 4, address width.
- DATA_W, 8, data width.
- SETUP_CYCLES, 1, cycles address/data are stable before the strobe (>=1).
- STROBE_CYCLES, 4, cycles rd/wr are held active (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 request; held until done0
- we0  in  1  port 0 direction: 1=write, 0=read
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  same for port 1
- done0  out  1  one-cycle pulse: port 0 transaction complete
- done1  out  1  one-cycle pulse: port 1 transaction complete
- rdata  out  DATA_W  last read data; valid from the done pulse until the next read completes
- busy  out  1  high while any transaction is in progress
- bus_addr  out  ADDR_W  memory address
- bus_wdata  out  DATA_W  data the top level drives onto the bus
- bus_oe  out  1  top-level tristate enable for bus_wdata
- bus_rd  out  1  1 = memory drives the bus
- bus_wr  out  1  write strobe to memory
- bus_rdata  in  DATA_W  bus value sampled for reads

Behaviour:
- Reset values: all outputs 0 (done*, busy, bus_oe, bus_rd, bus_wr, bus_addr, bus_wdata, rdata); state IDLE; round-robin pointer last=1, so port 0 wins the first tie.
- FSM states: IDLE, SETUP, STROBE, HOLD. A cycle counter is reloaded on each phase entry.
- IDLE:
  - If any req is high, choose the winner, latch its we/addr/wdata and its port id, then go to SETUP.
  - Arbitration is round-robin: if both requests are high, grant the port not equal to last. A lone request is granted immediately.
  - last updates at grant.
- SETUP (SETUP_CYCLES cycles):
  - bus_addr = latched address; busy=1.
  - Write: bus_oe=1 and bus_wdata driven.
  - Read: bus_rd=1, bus_oe=0.
- STROBE (STROBE_CYCLES cycles):
  - Write: bus_wr=1, bus_oe=1.
  - Read: bus_rd=1; rdata captures bus_rdata on the final STROBE cycle.
- HOLD (1 cycle):
  - bus_wr=0 and bus_rd=0.
  - Write: bus_oe stays 1 (data hold).
  - Read: bus_oe stays 0 (turnaround).
  - done<port> pulses in this cycle; next state is IDLE.
- Latency: with req sampled in IDLE at cycle 0, done asserts at cycle 1+SETUP_CYCLES+STROBE_CYCLES (6 with defaults).
- Back-to-back transactions: minimum one IDLE cycle between them, so 7 cycles per transaction with defaults.
- Invariants:
  - bus_oe and bus_rd are never both 1.
  - bus_wr is never 1 unless bus_oe is 1.
  - bus_addr is constant from SETUP through HOLD.
  - At most one done pulse per cycle.
- Requester inputs are ignored after grant. A req dropped mid-transaction does not abort it; done still pulses. A req still high on the cycle after done is a new request.
- rst mid-transaction forces IDLE and all outputs to 0 on the next edge. No done pulse is issued for the aborted transaction.
- Counters sized $clog2(max(SETUP_CYCLES,STROBE_CYCLES)+1). The counter must not wrap for parameter values up to 255.

Optional Feature:
- Macro: MEM_BUS_FIXED_PRIO_EN.
- Defined: port 0 has fixed priority on every tie; the round-robin pointer is removed. Port 1 can starve.
- Undefined: round-robin as described above.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD)
  - port-id constants PORT0=0, PORT1=1
  - default width constants ADDR_W=4, DATA_W=8
- One natural sub-module: mem_bus_rr_arb. It is a 2-way round-robin picker: inputs req[1:0], last, enable; outputs grant index and valid. It is purely combinational, with the pointer register held in the parent.
- The FSM and datapath latches stay in the parent.

Test Plan:
- Single write: req0=1, we0=1, addr0=4'h3, wdata0=8'hA5 at cycle 0.
  - Required: bus_oe=1 over cycles 1-6; bus_wr=1 exactly over cycles 2-5; bus_addr=3 over cycles 1-6; done0 pulses at cycle 6.
- Single read: req1=1, we1=0, addr1=4'h3, memory model returns 8'hA5.
  - Required: bus_rd=1 over cycles 1-5; bus_oe=0 throughout; rdata=8'hA5 with done1 at cycle 6.
- Contention: req0 and req1 raised together and held, both doing writes.
  - Required: grant order port0, port1, port0, port1; done pulses at cycles 6, 13, 20, 27.
  - With MEM_BUS_FIXED_PRIO_EN defined: only done0 pulses.
- Reset mid-strobe: assert rst at cycle 3 of a write.
  - Required: next cycle all bus outputs 0, no done pulse.
  - A subsequent req0 completes normally in 6 cycles.
- Invariant check, 1000 random cycles with random req/we/addr/data:
  - Never (bus_oe && bus_rd); never (bus_wr && !bus_oe).
  - Every accepted request gets exactly one done.
  - Memory model contents match a reference array.
